// File: rtl/power_on_seq.sv
// Purpose: bring-up sequencer: PLL lock -> SDRAM reset/init -> OV5640 PWDN/RESETB -> SCCB config -> LCD on.
// Latency: 2-cycle lock synchroniser; every output is registered and changes 1 cycle after its cause.
// Backpressure: none; done inputs are level-sampled and an absent done simply holds the state.
//
// Ports:
//   clk, rst                          100 MHz SDRAM-domain clock, synchronous active-high reset
//   pll_locked                        asynchronous PLL lock flag (double-flopped here)
//   sdram_init_done, sccb_cfg_done    level "done" flags from the SDRAM controller / SCCB configurator
//   sdram_rst_n, cam_pwdn, cam_rst_n  subsystem reset / power controls
//   sccb_start                        one-cycle configuration start pulse
//   lcd_en, seq_ready, seq_err        scan-out enable, RUN flag, FAULT flag
//   seq_state                         current state encoding (debug)
//
// Optional feature: define POWER_ON_SEQ_TIMEOUT_EN to bound the SDRAM_INIT and SCCB_CFG
// waits to T_TIMEOUT cycles and enter FAULT on expiry. Undefined: both waits are unbounded,
// FAULT is unreachable and seq_err stays 0.
module power_on_seq #(
  parameter int unsigned T_LOCK      = 16,
  parameter int unsigned T_SDRAM_RST = 1000,
  parameter int unsigned T_PWDN      = 100000,
  parameter int unsigned T_SCCB      = 2000000,
  parameter int unsigned T_TIMEOUT   = 4000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  input  logic       sccb_cfg_done,
  output logic       sdram_rst_n,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       sccb_start,
  output logic       lcd_en,
  output logic       seq_ready,
  output logic [2:0] seq_state,
  output logic       seq_err
);

`ifdef POWER_ON_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_SDRAM_RST  = 3'd1,
    ST_SDRAM_INIT = 3'd2,
    ST_CAM_PWDN   = 3'd3,
    ST_CAM_RST    = 3'd4,
    ST_SCCB_CFG   = 3'd5,
    ST_RUN        = 3'd6,
    ST_FAULT      = 3'd7
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so "N cycles" ends at N-1.
  localparam logic [23:0] LOCK_LAST    = 24'(T_LOCK - 1);
  localparam logic [23:0] SDRAM_LAST   = 24'(T_SDRAM_RST - 1);
  localparam logic [23:0] PWDN_LAST    = 24'(T_PWDN - 1);
  localparam logic [23:0] SCCB_LAST    = 24'(T_SCCB - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(T_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        lock_meta_q, lock_sync_q;
  logic        sdram_rst_n_q, sdram_rst_n_d;
  logic        cam_pwdn_q, cam_pwdn_d;
  logic        cam_rst_n_q, cam_rst_n_d;
  logic        sccb_start_q, sccb_start_d;
  logic        lcd_en_q, lcd_en_d;
  logic        seq_ready_q, seq_ready_d;
  logic        seq_err_q, seq_err_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 24'd1;
    sdram_rst_n_d = sdram_rst_n_q;
    cam_pwdn_d    = cam_pwdn_q;
    cam_rst_n_d   = cam_rst_n_q;
    sccb_start_d  = 1'b0;            // pulse: only raised on the CAM_RST -> SCCB_CFG edge
    lcd_en_d      = lcd_en_q;
    seq_ready_d   = seq_ready_q;
    seq_err_d     = seq_err_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (!lock_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_SDRAM_RST;
          cnt_d   = '0;
        end
      end
      ST_SDRAM_RST: begin
        if (cnt_q == SDRAM_LAST) begin
          state_d       = ST_SDRAM_INIT;
          cnt_d         = '0;
          sdram_rst_n_d = 1'b1;
        end
      end
      ST_SDRAM_INIT: begin
        if (sdram_init_done) begin
          state_d    = ST_CAM_PWDN;
          cnt_d      = '0;
          cam_pwdn_d = 1'b0;
        end else if (TIMEOUT_EN && cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_FAULT;
          cnt_d         = '0;
          sdram_rst_n_d = 1'b0;
          seq_err_d     = 1'b1;
        end
      end
      ST_CAM_PWDN: begin
        if (cnt_q == PWDN_LAST) begin
          state_d     = ST_CAM_RST;
          cnt_d       = '0;
          cam_rst_n_d = 1'b1;
        end
      end
      ST_CAM_RST: begin
        if (cnt_q == SCCB_LAST) begin
          state_d      = ST_SCCB_CFG;
          cnt_d        = '0;
          sccb_start_d = 1'b1;
        end
      end
      ST_SCCB_CFG: begin
        if (sccb_cfg_done) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          lcd_en_d    = 1'b1;
          seq_ready_d = 1'b1;
        end else if (TIMEOUT_EN && cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_FAULT;
          cnt_d         = '0;
          sdram_rst_n_d = 1'b0;
          cam_pwdn_d    = 1'b1;
          cam_rst_n_d   = 1'b0;
          seq_err_d     = 1'b1;
        end
      end
      default: begin
        // RUN and FAULT are parked; freeze the counter so it never wraps.
        cnt_d = cnt_q;
      end
    endcase

    // Lock loss overrides whatever the state logic decided this cycle (done or timer).
    // FAULT deliberately ignores it: only rst leaves FAULT.
    if (!lock_sync_q && state_q != ST_WAIT_LOCK && state_q != ST_FAULT) begin
      state_d       = ST_WAIT_LOCK;
      cnt_d         = '0;
      sdram_rst_n_d = 1'b0;
      cam_pwdn_d    = 1'b1;
      cam_rst_n_d   = 1'b0;
      sccb_start_d  = 1'b0;
      lcd_en_d      = 1'b0;
      seq_ready_d   = 1'b0;
      seq_err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_WAIT_LOCK;
      cnt_q         <= '0;
      lock_meta_q   <= 1'b0;
      lock_sync_q   <= 1'b0;
      sdram_rst_n_q <= 1'b0;
      cam_pwdn_q    <= 1'b1;
      cam_rst_n_q   <= 1'b0;
      sccb_start_q  <= 1'b0;
      lcd_en_q      <= 1'b0;
      seq_ready_q   <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lock_meta_q   <= pll_locked;
      lock_sync_q   <= lock_meta_q;
      sdram_rst_n_q <= sdram_rst_n_d;
      cam_pwdn_q    <= cam_pwdn_d;
      cam_rst_n_q   <= cam_rst_n_d;
      sccb_start_q  <= sccb_start_d;
      lcd_en_q      <= lcd_en_d;
      seq_ready_q   <= seq_ready_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign sdram_rst_n = sdram_rst_n_q;
  assign cam_pwdn    = cam_pwdn_q;
  assign cam_rst_n   = cam_rst_n_q;
  assign sccb_start  = sccb_start_q;
  assign lcd_en      = lcd_en_q;
  assign seq_ready   = seq_ready_q;
  assign seq_state   = state_q;
  assign seq_err     = TIMEOUT_EN & seq_err_q;

endmodule

// File: tb/tb_power_on_seq.sv
// Purpose: self-checking bench for power_on_seq with small timing parameters.
// Latency: expected latencies are derived from the sequencing rules with plain arithmetic.
// Backpressure: not applicable; done inputs are driven as levels with random delays.
module tb_power_on_seq;

  localparam int T_LOCK      = 4;
  localparam int T_SDRAM_RST = 10;
  localparam int T_PWDN      = 20;
  localparam int T_SCCB      = 30;
  localparam int T_TIMEOUT   = 50;
  localparam int SYNC        = 2;

  // Expected latencies, measured in rising edges from the causing input change.
  localparam int EXP_RST_REL = SYNC + T_LOCK + T_SDRAM_RST;   // pll_locked rise -> sdram_rst_n rise
  localparam int EXP_DONE    = 1;                             // done input -> output change
  localparam int EXP_LOSS    = SYNC + 1;                      // pll_locked fall -> WAIT_LOCK

  localparam int S_SDRAM_RST_N = 0;
  localparam int S_CAM_PWDN    = 1;
  localparam int S_CAM_RST_N   = 2;
  localparam int S_SCCB_START  = 3;
  localparam int S_LCD_EN      = 4;
  localparam int S_STATE       = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sdram_init_done;
  logic       sccb_cfg_done;
  logic       sdram_rst_n, cam_pwdn, cam_rst_n, sccb_start, lcd_en, seq_ready, seq_err;
  logic [2:0] seq_state;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit pulse_wide = 1'b0;
  bit prev_start = 1'b0;

  power_on_seq #(
    .T_LOCK(T_LOCK), .T_SDRAM_RST(T_SDRAM_RST), .T_PWDN(T_PWDN),
    .T_SCCB(T_SCCB), .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked),
    .sdram_init_done(sdram_init_done), .sccb_cfg_done(sccb_cfg_done),
    .sdram_rst_n(sdram_rst_n), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
    .sccb_start(sccb_start), .lcd_en(lcd_en), .seq_ready(seq_ready),
    .seq_state(seq_state), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Count sccb_start pulses and flag any that last longer than one cycle.
  always @(negedge clk) begin
    if (sccb_start) begin
      pulses = pulses + 1;
      if (prev_start) pulse_wide = 1'b1;
    end
    prev_start = sccb_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int get_sig(input int sel);
    case (sel)
      S_SDRAM_RST_N: return int'(sdram_rst_n);
      S_CAM_PWDN:    return int'(cam_pwdn);
      S_CAM_RST_N:   return int'(cam_rst_n);
      S_SCCB_START:  return int'(sccb_start);
      S_LCD_EN:      return int'(lcd_en);
      default:       return int'(seq_state);
    endcase
  endfunction

  // Edges until the selected output equals val; -1 if the budget runs out.
  task automatic wait_sig(input int sel, input int val, input int budget, output int n);
    bit hit = 1'b0;
    n = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      if (get_sig(sel) == val) hit = 1'b1;
    end
    if (!hit) n = -1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".sdram_rst_n"}, int'(sdram_rst_n), 0);
    chk({tag, ".cam_pwdn"},    int'(cam_pwdn),    1);
    chk({tag, ".cam_rst_n"},   int'(cam_rst_n),   0);
    chk({tag, ".sccb_start"},  int'(sccb_start),  0);
    chk({tag, ".lcd_en"},      int'(lcd_en),      0);
    chk({tag, ".seq_ready"},   int'(seq_ready),   0);
    chk({tag, ".seq_err"},     int'(seq_err),     0);
    chk({tag, ".seq_state"},   int'(seq_state),   0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    sdram_init_done = 1'b0;
    sccb_cfg_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int d;
    int h;
    int l;

    // Reset state
    do_reset();
    chk_reset_vals("reset");
    repeat (5) tick();
    chk("no_lock_idle.state", int'(seq_state), 0);

    // Nominal bring-up with random done delays
    pll_locked = 1'b1;
    wait_sig(S_SDRAM_RST_N, 1, 100, n);
    chk("nom.sdram_rst_rise", n, EXP_RST_REL);
    chk("nom.state_init", int'(seq_state), 2);
    d = $urandom_range(1, 8);
    repeat (d) tick();
    chk("nom.still_init", int'(seq_state), 2);
    chk("nom.pwdn_held", int'(cam_pwdn), 1);
    sdram_init_done = 1'b1;
    wait_sig(S_CAM_PWDN, 0, 100, n);
    chk("nom.pwdn_fall", n, EXP_DONE);
    wait_sig(S_CAM_RST_N, 1, 100, n);
    chk("nom.cam_rst_rise", n, T_PWDN);
    wait_sig(S_SCCB_START, 1, 100, n);
    chk("nom.sccb_start", n, T_SCCB);
    chk("nom.state_cfg", int'(seq_state), 5);
    tick();
    chk("nom.sccb_start_width", int'(sccb_start), 0);
    d = $urandom_range(0, 8);
    repeat (d) tick();
    chk("nom.lcd_wait", int'(lcd_en), 0);
    sccb_cfg_done = 1'b1;
    wait_sig(S_LCD_EN, 1, 100, n);
    chk("nom.lcd_en", n, EXP_DONE);
    chk("nom.seq_ready", int'(seq_ready), 1);
    chk("nom.state_run", int'(seq_state), 6);
    sdram_init_done = 1'b0;
    sccb_cfg_done = 1'b0;
    d = $urandom_range(5, 20);
    repeat (d) tick();
    chk("nom.run_holds", int'(seq_state), 6);
    chk("nom.pulses", pulses, 1);

    // Lock lost in RUN, then full repeat with init_done already high on entry
    pll_locked = 1'b0;
    wait_sig(S_STATE, 0, 20, n);
    chk("loss.to_wait", n, EXP_LOSS);
    chk("loss.lcd_en", int'(lcd_en), 0);
    chk("loss.cam_pwdn", int'(cam_pwdn), 1);
    chk("loss.sdram_rst_n", int'(sdram_rst_n), 0);
    chk("loss.cam_rst_n", int'(cam_rst_n), 0);
    chk("loss.seq_ready", int'(seq_ready), 0);
    repeat (3) tick();
    sdram_init_done = 1'b1;
    pll_locked = 1'b1;
    wait_sig(S_SDRAM_RST_N, 1, 100, n);
    chk("rep.sdram_rst_rise", n, EXP_RST_REL);
    wait_sig(S_CAM_PWDN, 0, 100, n);
    chk("rep.done_on_entry", n, 1);
    wait_sig(S_CAM_RST_N, 1, 100, n);
    chk("rep.cam_rst_rise", n, T_PWDN);
    wait_sig(S_SCCB_START, 1, 100, n);
    chk("rep.sccb_start", n, T_SCCB);
    sccb_cfg_done = 1'b1;
    wait_sig(S_LCD_EN, 1, 100, n);
    chk("rep.lcd_en", n, EXP_DONE);
    chk("rep.pulses", pulses, 2);

    // Lock glitches shorter than T_LOCK restart qualification
    for (int i = 0; i < 3; i++) begin
      do_reset();
      tick();
      h = $urandom_range(1, T_LOCK - 1);
      l = $urandom_range(1, 3);
      pll_locked = 1'b1;
      repeat (h) tick();
      pll_locked = 1'b0;
      repeat (l) tick();
      pll_locked = 1'b1;
      wait_sig(S_SDRAM_RST_N, 1, 100, n);
      chk($sformatf("glitch%0d.h%0d_l%0d.rise", i, h, l), n, EXP_RST_REL);
    end

    // init_done and lock drop reach the sequencer on the same edge: lock loss wins
    do_reset();
    pll_locked = 1'b1;
    wait_sig(S_SDRAM_RST_N, 1, 100, n);
    chk("simul.in_init", int'(seq_state), 2);
    pll_locked = 1'b0;
    repeat (SYNC) tick();
    sdram_init_done = 1'b1;
    tick();
    chk("simul.state", int'(seq_state), 0);
    chk("simul.cam_pwdn", int'(cam_pwdn), 1);
    tick();
    chk("simul.cam_pwdn_after", int'(cam_pwdn), 1);

    // rst pulsed while in CAM_RST
    do_reset();
    sdram_init_done = 1'b1;
    pll_locked = 1'b1;
    wait_sig(S_CAM_RST_N, 1, 200, n);
    chk("rstmid.in_cam_rst", int'(seq_state), 4);
    d = $urandom_range(1, 10);
    repeat (d) tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("rstmid");
    rst = 1'b0;
    wait_sig(S_SDRAM_RST_N, 1, 100, n);
    chk("rstmid.restart_rise", n, EXP_RST_REL);

    // SDRAM init never completes
    do_reset();
    pll_locked = 1'b1;
    wait_sig(S_SDRAM_RST_N, 1, 100, n);
`ifdef POWER_ON_SEQ_TIMEOUT_EN
    wait_sig(S_STATE, 7, 200, n);
    chk("tmo.fault_after", n, T_TIMEOUT);
    chk("tmo.seq_err", int'(seq_err), 1);
    chk("tmo.sdram_rst_n", int'(sdram_rst_n), 0);
    chk("tmo.cam_pwdn", int'(cam_pwdn), 1);
    chk("tmo.seq_ready", int'(seq_ready), 0);
    pll_locked = 1'b0;
    repeat (4) tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("tmo.lock_ignored", int'(seq_state), 7);
    chk("tmo.err_held", int'(seq_err), 1);
    rst = 1'b1;
    tick();
    chk_reset_vals("tmo.rst");
    rst = 1'b0;
`else
    repeat (4 * T_TIMEOUT) tick();
    chk("notmo.state", int'(seq_state), 2);
    chk("notmo.seq_err", int'(seq_err), 0);
`endif

    chk("sccb_pulse_single", int'(pulse_wide), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
